// File: rtl/result_collector_pkg.sv
// Definitions: shared width constants, collector FSM states and the packed lane-result type.
package Definitions;
  localparam int WORD_LENGTH = 16;
  localparam int LANES = 4;
  typedef enum logic {IDLE, ACTIVE} collector_state_t;
  typedef logic [LANES-1:0][WORD_LENGTH-1:0] PROCESSOR_RESULT;
endpackage

// File: rtl/result_collector_fifo.sv
// result_fifo: circular buffer taking up to LANES words per cycle and popping one.
module result_fifo #(
  parameter int WORD_LENGTH = 16,
  parameter int LANES = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CW-1:0]                wr_count_i,
  input  logic [LANES*WORD_LENGTH-1:0] wr_data_i,
  input  logic                         pop_i,
  output logic [WORD_LENGTH-1:0]       head_o,
  output logic [CW-1:0]                count_o,
  output logic [CW-1:0]                free_o
);
  logic [WORD_LENGTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic pop;
  assign pop = pop_i && count_q != '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(wr_count_i);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_q + wr_count_i - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (CW'(i) < wr_count_i) mem_q[wr_ptr_q + AW'(i)] <= wr_data_i[i*WORD_LENGTH +: WORD_LENGTH];
  end
  // Head is forced to zero when empty so stale storage never reaches the output.
  assign head_o  = count_q != '0 ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;
  assign free_o  = CW'(DEPTH) - count_q;
endmodule

// File: rtl/result_collector.sv
// result_collector: captures per-pass lane results into a FIFO and streams N words out in row order.
module result_collector #(
  parameter int WORD_LENGTH = Definitions::WORD_LENGTH,
  parameter int LANES = Definitions::LANES,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [3:0]                   N,
  input  logic                         capture,
  input  logic [LANES*WORD_LENGTH-1:0] result,
  output logic [WORD_LENGTH-1:0]       out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow
);
  import Definitions::collector_state_t;
  import Definitions::IDLE;
  import Definitions::ACTIVE;
  localparam int CW = $clog2(DEPTH) + 1;
  collector_state_t state_q, state_d;
  logic [3:0] n_q, n_d, to_capture_q, to_capture_d, emitted_q, emitted_d, k;
  logic overflow_q, overflow_d, done_q, done_d, cap, fits, pop;
  logic [CW-1:0] count, free, wr_count;
  result_fifo #(.WORD_LENGTH(WORD_LENGTH), .LANES(LANES), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .wr_count_i(wr_count), .wr_data_i(result),
    .pop_i(pop), .head_o(out_data), .count_o(count), .free_o(free)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      to_capture_q <= '0;
      emitted_q    <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      to_capture_q <= to_capture_d;
      emitted_q    <= emitted_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
    end
  end
  // Free space is judged on occupancy before this cycle's pop, so a full FIFO rejects even while draining.
  always_comb begin
    k = to_capture_q < 4'(LANES) ? to_capture_q : 4'(LANES);
    cap = state_q == ACTIVE && capture && to_capture_q != '0;
    fits = free >= CW'(k);
    wr_count = cap && fits ? CW'(k) : '0;
    pop = out_valid && out_ready;
    state_d = state_q;
    n_d = n_q;
    to_capture_d = to_capture_q;
    emitted_d = emitted_q;
    overflow_d = overflow_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start && N != '0) begin
        state_d = ACTIVE;
        n_d = N;
        to_capture_d = N;
        emitted_d = '0;
        overflow_d = 1'b0;
      end
    end else begin
      to_capture_d = cap && fits ? to_capture_q - k : to_capture_q;
      overflow_d = overflow_q || (cap && !fits);
      emitted_d = emitted_q + 4'(pop);
      if (pop && emitted_d == n_q) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    end
  end
  assign out_valid = count != '0;
  assign busy = state_q == ACTIVE;
  assign done = done_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: scoreboard bench; expected words queued at capture, checked on each handshake.
module tb_result_collector;
  logic clk = 0, reset, start, capture, out_ready, out_valid, busy, done, overflow;
  logic [3:0] N;
  logic [63:0] result;
  logic [15:0] out_data, mon_exp, hold;
  logic [15:0] exp_q[$];
  int checks = 0, errors = 0, done_cnt = 0, d0;
  bit held;

  result_collector dut (
    .clk(clk), .reset(reset), .start(start), .N(N), .capture(capture), .result(result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && done) done_cnt++;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got %0d expected none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          errors++;
          $display("FAIL pop_data got %0d expected %0d", out_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] n);
    N = n;
    start = 1;
    tick();
    start = 0;
    N = 0;
  endtask

  task automatic do_capture(input logic [15:0] a, b, c, d);
    result = {d, c, b, a};
    capture = 1;
    tick();
    capture = 0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy; i++) tick();
  endtask

  task automatic test_reset();
    #2;
    checks += 5;
    if (out_data !== 16'd0) begin errors++; $display("FAIL reset_data got %0d expected 0", out_data); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b expected 0", overflow); end
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_idle();
    do_start(4'd0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_n0_busy got %b expected 0", busy); end
    do_capture(16'd1, 16'd2, 16'd3, 16'd4);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_cap_valid got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_cap_busy got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    out_ready = 1;
    d0 = done_cnt;
    do_start(4'd4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b expected 1", busy); end
    exp_q.push_back(16'd10); exp_q.push_back(16'd20); exp_q.push_back(16'd30); exp_q.push_back(16'd40);
    do_capture(16'd10, 16'd20, 16'd30, 16'd40);
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_valid got %b expected 1", out_valid); end
    if (out_data !== 16'd10) begin errors++; $display("FAIL basic_latency_data got %0d expected 10", out_data); end
    wait_idle(20);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b expected 0", busy); end
    if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b expected 1", done); end
    tick();
    checks += 4;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b expected 0", done); end
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_count got %0d expected 1", done_cnt - d0); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b expected 0", overflow); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_left got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    d0 = done_cnt;
    do_start(4'd6);
    for (int i = 1; i <= 6; i++) exp_q.push_back(16'(i));
    do_capture(16'd1, 16'd2, 16'd3, 16'd4);
    do_capture(16'd5, 16'd6, 16'd7, 16'd8);
    wait_idle(20);
    tick();
    checks += 4;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL six_done_count got %0d expected 1", done_cnt - d0); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL six_left got %0d expected 0", exp_q.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL six_busy got %b expected 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL six_extra_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    out_ready = 0;
    d0 = done_cnt;
    do_start(4'd15);
    for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
    do_capture(16'd1, 16'd2, 16'd3, 16'd4);
    do_capture(16'd5, 16'd6, 16'd7, 16'd8);
    do_capture(16'd9, 16'd10, 16'd11, 16'd12);
    checks += 3;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b expected 1", overflow); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b expected 1", out_valid); end
    if (out_data !== 16'd1) begin errors++; $display("FAIL ovf_head got %0d expected 1", out_data); end
    out_ready = 1;
    repeat (10) tick();
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b expected 0", out_valid); end
    if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b expected 1", busy); end
    if (done_cnt - d0 !== 0) begin errors++; $display("FAIL ovf_early_done got %0d expected 0", done_cnt - d0); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL ovf_left got %0d expected 0", exp_q.size()); end
    for (int i = 21; i <= 24; i++) exp_q.push_back(16'(i));
    do_capture(16'd21, 16'd22, 16'd23, 16'd24);
    for (int i = 31; i <= 33; i++) exp_q.push_back(16'(i));
    do_capture(16'd31, 16'd32, 16'd33, 16'd34);
    wait_idle(20);
    tick();
    checks += 3;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ovf_done_count got %0d expected 1", done_cnt - d0); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b expected 1", overflow); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL ovf_final_left got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    out_ready = 0;
    d0 = done_cnt;
    do_start(4'd4);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL stall_ovf_cleared got %b expected 0", overflow); end
    exp_q.push_back(16'd100); exp_q.push_back(16'd200); exp_q.push_back(16'd300); exp_q.push_back(16'd400);
    do_capture(16'd100, 16'd200, 16'd300, 16'd400);
    for (int i = 0; i < 20 && busy; i++) begin
      out_ready = (i % 2 == 0);
      held = !out_ready && out_valid;
      hold = out_data;
      tick();
      if (held) begin
        checks++;
        if (out_data !== hold) begin errors++; $display("FAIL stall_hold got %0d expected %0d", out_data, hold); end
      end
    end
    tick();
    checks += 2;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL stall_done_count got %0d expected 1", done_cnt - d0); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL stall_left got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    do_start(4'd4);
    exp_q.push_back(16'd10); exp_q.push_back(16'd20); exp_q.push_back(16'd30); exp_q.push_back(16'd40);
    do_capture(16'd10, 16'd20, 16'd30, 16'd40);
    tick();
    tick();
    reset = 1;
    #1;
    checks += 4;
    if (out_data !== 16'd0) begin errors++; $display("FAIL rstmid_data got %0d expected 0", out_data); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b expected 0", done); end
    exp_q.delete();
    d0 = done_cnt;
    tick();
    reset = 0;
    tick();
    checks++;
    if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d expected 0", done_cnt - d0); end
    do_start(4'd2);
    exp_q.push_back(16'd7); exp_q.push_back(16'd8);
    do_capture(16'd7, 16'd8, 16'd9, 16'd10);
    wait_idle(20);
    tick();
    checks += 3;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rstmid_done_count got %0d expected 1", done_cnt - d0); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL rstmid_left got %0d expected 0", exp_q.size()); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_extra got %b expected 0", out_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1; start = 0; N = 0; capture = 0; result = 0; out_ready = 0;
    test_reset();
    test_idle();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_collector.md
# result_collector

Downstream stage of the processor array in the matrix-vector datapath. Captures the per-lane results the array produces at the end of each pass, buffers them in a multi-write FIFO, and streams them out one word per cycle in row order over a valid/ready handshake. Tracks the matrix size N latched at start. Pulses `done` when all N results have been delivered.

## Interface
Parameters:
- `WORD_LENGTH`, 16: width of one processor result.
- `LANES`, 4: number of processors (results per pass).
- `DEPTH`, 8: FIFO entries; power of two, ≥ LANES.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: one-cycle pulse; begins a new vector, latches `N`.
- `N` in 4: rows in the matrix, 1..15; 0 means `start` is ignored.
- `capture` in 1: one-cycle pulse; `result` holds a completed pass.
- `result` in LANES*WORD_LENGTH: lane 0 in LSBs; lane i is row (pass*LANES + i).
- `out_data` out WORD_LENGTH: FIFO head.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts `out_data` when high together with `out_valid`.
- `busy` out 1: high from `start` acceptance until `done`.
- `done` out 1: one-cycle pulse after the last of N words is accepted.
- `overflow` out 1: sticky error; cleared only by reset or the next accepted `start`.

## Operation
- Reset values: `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `overflow`=0; FIFO empty; FSM in IDLE.
- FSM states:
  - IDLE: `start` with `N`≠0 latches N, sets `to_capture`=N and `emitted`=0, clears `overflow`, goes to ACTIVE.
  - ACTIVE: runs capture and drain; moves to IDLE when `emitted` reaches N.
  - `start` in ACTIVE is ignored.
- Capture, in ACTIVE only: k = min(LANES, `to_capture`).
  - If free entries ≥ k: write lanes 0..k-1 in one cycle, lane order preserved, then `to_capture` -= k.
  - Otherwise drop the whole capture, set `overflow`, leave `to_capture` unchanged.
  - Capture is ignored in IDLE or when `to_capture`=0.
- Free-space check uses occupancy before this cycle's pop.
- Drain: a pop occurs on `out_valid` && `out_ready`; `emitted` += 1.
  - When the pop makes `emitted` equal N: pulse `done` next cycle, drop `busy`, return to IDLE.
- Simultaneous capture and pop: both take effect; occupancy = old + k − 1.
- Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- `out_data` is unchanged while `out_valid` && !`out_ready`.
- Reset asserted mid-vector: everything is discarded immediately. No `done` is produced.

## Timing
- Capture at edge t: lane 0 is on `out_data` with `out_valid` high after edge t+1 (latency 1, FIFO was empty).
- Throughput: one word per cycle while `out_ready` is held high.
- `done` asserts in the cycle after the final handshake.
- `busy` deasserts in that same cycle.
- A `start` in that same cycle is accepted, because the FSM is already in IDLE.
- `start` acceptance: `busy` is high at the next edge.

## Structure
- Shared package `Definitions`:
  - `WORD_LENGTH` constant.
  - `collector_state_t` enum {IDLE, ACTIVE}.
  - Packed `PROCESSOR_RESULT` struct/array for the lanes.
- Sub-module `result_fifo`: DEPTH×WORD_LENGTH circular buffer.
  - Writes up to LANES words per cycle.
  - Pops one word per cycle.
  - Exposes occupancy and free count.
- The FSM, counters and overflow logic live in `result_collector`.

## Test plan
- N=4, `out_ready`=1, one capture with lanes {10,20,30,40} → `out_data` 10,20,30,40 on four consecutive cycles starting one cycle after capture; `done` pulses once; `overflow`=0.
- N=6, two captures {1,2,3,4} then {5,6,7,8} → output 1..6 only; 7 and 8 are discarded; `done` after the 6th word.
- N=15, `out_ready`=0, three captures → third capture dropped; `overflow`=1; occupancy 8. Release `out_ready` → 8 words drain; no `done` until the remaining captures arrive.
- `out_ready` toggling 1,0,1,0 with N=4 → each word is held stable while stalled; no word is duplicated or lost.
- Reset asserted after 2 of 4 words → all outputs are 0 asynchronously; no `done`. New `start` with N=2 proceeds normally.
- `start` with N=0, and `capture` while IDLE → no state change; `busy`=0; `out_valid`=0.
